// File: rtl/shift_add_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : shift_add_mul_seq_pkg
//  Purpose : Shared widths, FSM state encoding and bit-scan helpers for the
//            sequential shift-and-add multiplier.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package shift_add_mul_seq_pkg;

  localparam int DATA_W  = 16;
  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // True when any bit of v strictly above position idx is set.
  // Used to detect that no further multiplier bits remain.
  function automatic logic bits_above(input logic [DATA_W-1:0]  v,
                                      input logic [SHIFT_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if ((i > int'(idx)) && v[i]) r = 1'b1;
    end
    return r;
  endfunction

  // True when shifting v left by idx pushes a set bit out of the top,
  // i.e. any bit in v[DATA_W-1 : DATA_W-idx] is set (never for idx = 0).
  function automatic logic bits_lost(input logic [DATA_W-1:0]  v,
                                     input logic [SHIFT_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (((i + int'(idx)) >= DATA_W) && v[i]) r = 1'b1;
    end
    return r;
  endfunction

endpackage : shift_add_mul_seq_pkg
`default_nettype wire

// File: rtl/shift_add_mul_seq_shl.sv
`default_nettype none
// ============================================================================
//  Module  : MuxShiftLeftSimple
//  Purpose : Combinational 16-bit logical left shift (zero fill).
//  Ports   : A  - data in (16)
//            OP - shift amount (4)
//            R  - A shifted left by OP (16)
//  Revision: 1.0  initial release
// ============================================================================
module MuxShiftLeftSimple
  import shift_add_mul_seq_pkg::*;
(
  input  logic [DATA_W-1:0]  A,
  input  logic [SHIFT_W-1:0] OP,
  output logic [DATA_W-1:0]  R
);

  assign R = A << OP;

endmodule : MuxShiftLeftSimple
`default_nettype wire

// File: rtl/shift_add_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module  : shift_add_mul_seq
//  Purpose : Sequential 16x16 unsigned shift-and-add multiplier returning the
//            low 16 bits of the product plus an overflow flag.
//  Ports   : clk   - clock, rising edge
//            rst   - asynchronous active-high reset
//            start - operation request, honoured only in IDLE
//            a, b  - multiplicand / multiplier (16, unsigned)
//            busy  - high while iterating (RUN)
//            done  - one-cycle pulse when p/ovf are updated
//            p     - low 16 bits of a*b, held until next completion
//            ovf   - product did not fit in 16 bits, held with p
//  Params  : EARLY_EXIT - 1: stop once no multiplier bits remain above idx
//                         0: always iterate over all 16 bits
//  Revision: 1.0  initial release
// ============================================================================
module shift_add_mul_seq
  import shift_add_mul_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] p,
  output logic              ovf
);

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    ar, ar_nxt;
  logic [DATA_W-1:0]    br, br_nxt;
  logic [DATA_W:0]      acc, acc_nxt;
  logic [SHIFT_W-1:0]   idx, idx_nxt;
  logic                 flag, flag_nxt;
  logic [DATA_W-1:0]    p_nxt;
  logic                 ovf_nxt;
  logic                 done_nxt;

  logic [DATA_W-1:0]    shifted;
  logic [DATA_W:0]      sum;

  MuxShiftLeftSimple u_shl (
    .A  (ar),
    .OP (idx),
    .R  (shifted)
  );

  // Only the low 16 bits of the accumulator participate; bit 16 of the sum
  // is the carry that marks overflow.
  assign sum  = {1'b0, acc[DATA_W-1:0]} + {1'b0, shifted};
  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    ar_nxt    = ar;
    br_nxt    = br;
    acc_nxt   = acc;
    idx_nxt   = idx;
    flag_nxt  = flag;
    p_nxt     = p;
    ovf_nxt   = ovf;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          ar_nxt    = a;
          br_nxt    = b;
          acc_nxt   = '0;
          idx_nxt   = '0;
          flag_nxt  = 1'b0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (br[idx]) begin
          acc_nxt = sum;
          if (sum[DATA_W] || bits_lost(ar, idx)) flag_nxt = 1'b1;
        end
        // The exit cycle still performs its add above; idx is left in place
        // so it never wraps.
        if ((idx == SHIFT_W'(DATA_W - 1)) ||
            (EARLY_EXIT && !bits_above(br, idx))) begin
          state_nxt = FIN;
        end else begin
          idx_nxt = idx + SHIFT_W'(1);
        end
      end

      FIN: begin
        p_nxt     = acc[DATA_W-1:0];
        ovf_nxt   = flag;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ar    <= '0;
      br    <= '0;
      acc   <= '0;
      idx   <= '0;
      flag  <= 1'b0;
      p     <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ar    <= ar_nxt;
      br    <= br_nxt;
      acc   <= acc_nxt;
      idx   <= idx_nxt;
      flag  <= flag_nxt;
      p     <= p_nxt;
      ovf   <= ovf_nxt;
      done  <= done_nxt;
    end
  end

endmodule : shift_add_mul_seq
`default_nettype wire

// File: tb/tb_shift_add_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_shift_add_mul_seq
//  Purpose : Directed self-checking bench for shift_add_mul_seq; one instance
//            with full iteration, one with early exit.
//  Revision: 1.0  initial release
// ============================================================================
module tb_shift_add_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [15:0] a, b;
  logic        busy0, done0, ovf0;
  logic        busy1, done1, ovf1;
  logic [15:0] p0, p1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_add_mul_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .p(p0), .ovf(ovf0)
  );

  shift_add_mul_seq #(.EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .p(p1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation on the selected instance. Inputs change on the
  // falling edge; outputs are sampled on the falling edge.
  task automatic run_op(input bit ee, input logic [15:0] ta, input logic [15:0] tb_v,
                        input int exp_cyc, input logic [15:0] exp_p,
                        input logic exp_ovf, input string tag, input bit repulse);
    int cyc;
    @(negedge clk);
    a = ta; b = tb_v;
    if (ee) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    cyc = 0;
    while ((ee ? busy1 : busy0) && cyc < 100) begin
      cyc++;
      if (repulse && cyc == 3) begin
        a = 16'hFFFF; b = 16'hFFFF;
        if (ee) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(negedge clk);
    end
    start0 = 1'b0; start1 = 1'b0;
    check({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " done_early"}, {31'd0, (ee ? done1 : done0)}, 32'd0);
    @(negedge clk);
    check({tag, " done"}, {31'd0, (ee ? done1 : done0)}, 32'd1);
    check({tag, " p"},    {16'd0, (ee ? p1 : p0)},       {16'd0, exp_p});
    check({tag, " ovf"},  {31'd0, (ee ? ovf1 : ovf0)},   {31'd0, exp_ovf});
    @(negedge clk);
    check({tag, " done_pulse_end"}, {31'd0, (ee ? done1 : done0)}, 32'd0);
    check({tag, " p_held"}, {16'd0, (ee ? p1 : p0)}, {16'd0, exp_p});
  endtask

  initial begin
    int saw_done;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst busy0", {31'd0, busy0}, 32'd0);
    check("rst done0", {31'd0, done0}, 32'd0);
    check("rst p0",    {16'd0, p0},    32'd0);
    check("rst ovf0",  {31'd0, ovf0},  32'd0);
    check("rst busy1", {31'd0, busy1}, 32'd0);
    check("rst p1",    {16'd0, p1},    32'd0);
    rst = 1'b0;

    run_op(1'b0, 16'h0003, 16'h0005, 16, 16'h000F, 1'b0, "ee0_3x5", 1'b0);
    run_op(1'b1, 16'h00FF, 16'h0101,  9, 16'hFFFF, 1'b0, "ee1_ffx101", 1'b0);
    run_op(1'b0, 16'h00FF, 16'h0101, 16, 16'hFFFF, 1'b0, "ee0_ffx101", 1'b0);
    run_op(1'b1, 16'h8000, 16'h0002,  2, 16'h0000, 1'b1, "ee1_lost_bit", 1'b0);
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 16, 16'h0001, 1'b1, "ee1_max", 1'b0);
    run_op(1'b1, 16'h1234, 16'h0000,  1, 16'h0000, 1'b0, "ee1_b0", 1'b0);
    run_op(1'b1, 16'h6000, 16'h0003,  2, 16'h2000, 1'b1, "ee1_carry", 1'b0);
    run_op(1'b1, 16'h0100, 16'h0101,  9, 16'h0100, 1'b1, "ee1_sticky", 1'b0);
    run_op(1'b0, 16'h0007, 16'h0009, 16, 16'h003F, 1'b0, "ee0_repulse", 1'b1);

    // Abort in the middle of an operation.
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy0}, 32'd0);
    check("abort p",    {16'd0, p0},    32'd0);
    check("abort ovf",  {31'd0, ovf0},  32'd0);
    check("abort done", {31'd0, done0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 || busy0) saw_done = 1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);

    run_op(1'b0, 16'h0002, 16'h0003, 16, 16'h0006, 1'b0, "ee0_after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_shift_add_mul_seq
`default_nettype wire
